// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state codes, NACK stage codes and R/W bit constants for the I2C burst-read master
package i2c_pkg;
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_TX     = 4'd2;
    localparam logic [3:0] ST_ACK    = 4'd3;
    localparam logic [3:0] ST_RSTART = 4'd4;
    localparam logic [3:0] ST_RX     = 4'd5;
    localparam logic [3:0] ST_MACK   = 4'd6;
    localparam logic [3:0] ST_STOP   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;
    localparam logic [1:0] NACK_STAGE_NONE  = 2'd0;
    localparam logic [1:0] NACK_STAGE_DEV_W = 2'd1;
    localparam logic [1:0] NACK_STAGE_REG   = 2'd2;
    localparam logic [1:0] NACK_STAGE_DEV_R = 2'd3;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    // first SDA enable of a transmitted byte plus the byte pre-shifted past its MSB
    function automatic logic [8:0] tx_first(input logic [7:0] b);
        return {~b[7], b[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: free-running SCL period counter with mid-high and mid-low ticks while enabled
module i2c_scl_gen #(
    parameter int CLK_DIV = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic scl,
    output logic hi_mid,
    output logic lo_mid
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    // count 0..CLK_DIV-1 while enabled, park at 0 otherwise so each frame starts on a high phase
    always_comb cnt_d = !en ? '0 : (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    // period counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign scl    = !en || (cnt_q < CW'(CLK_DIV / 2));
    assign hi_mid = en && (cnt_q == CW'(CLK_DIV / 4));
    assign lo_mid = en && (cnt_q == CW'(3 * CLK_DIV / 4));
endmodule

// File: rtl/i2c_burst_read_master.sv
// i2c_burst_read_master: START, dev+W, reg, repeated START, dev+R, N data bytes, STOP
module i2c_burst_read_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 24,
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] byte_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic [1:0]       nack_stage,
    output logic             scl,
    inout  wire              sda,
    output logic             sda_oe
);
    logic [3:0]       state_q, state_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       sh_q, sh_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       stg_q, stg_d;
    logic             oe_q, oe_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             nack_err_q, nack_err_d;
    logic [1:0]       nack_stage_q, nack_stage_d;
    logic             hi_mid, lo_mid;

    assign busy       = state_q != ST_IDLE;
    assign done       = state_q == ST_DONE;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign nack_err   = nack_err_q;
    assign nack_stage = nack_stage_q;
    assign sda_oe     = oe_q;
    assign sda        = oe_q ? 1'b0 : 1'bz;

    i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl (
        .clk    (clk),
        .rst    (rst),
        .en     (busy),
        .scl    (scl),
        .hi_mid (hi_mid),
        .lo_mid (lo_mid)
    );

    // frame sequencing: SDA moves at lo_mid, is sampled at hi_mid, START/STOP edges at hi_mid
    always_comb begin
        state_d      = state_q;
        dev_d        = dev_q;
        reg_d        = reg_q;
        rem_d        = rem_q;
        sh_d         = sh_q;
        bit_d        = bit_q;
        stg_d        = stg_q;
        oe_d         = oe_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        nack_err_d   = nack_err_q;
        nack_stage_d = nack_stage_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d      = ST_START;
                dev_d        = dev_addr;
                reg_d        = reg_addr;
                rem_d        = (byte_len == '0) ? LEN_W'(1) :
                               (byte_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : byte_len;
                nack_err_d   = 1'b0;
                nack_stage_d = NACK_STAGE_NONE;
            end
            ST_START, ST_RSTART: begin
                if (hi_mid) oe_d = 1'b1;
                if (lo_mid) begin
                    state_d      = ST_TX;
                    bit_d        = '0;
                    stg_d        = (state_q == ST_START) ? NACK_STAGE_DEV_W : NACK_STAGE_DEV_R;
                    {oe_d, sh_d} = tx_first({dev_q, (state_q == ST_START) ? RW_WRITE : RW_READ});
                end
            end
            ST_TX: if (lo_mid) begin
                if (bit_q == 4'd7) begin
                    state_d = ST_ACK;
                    oe_d    = 1'b0;
                end else begin
                    oe_d  = ~sh_q[7];
                    sh_d  = {sh_q[6:0], 1'b0};
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (hi_mid && sda) begin
                    nack_err_d   = 1'b1;
                    nack_stage_d = stg_q;
                end
                if (lo_mid) begin
                    if (nack_err_q) begin
                        state_d = ST_STOP;
                        oe_d    = 1'b1;
                    end else if (stg_q == NACK_STAGE_DEV_W) begin
                        state_d      = ST_TX;
                        bit_d        = '0;
                        stg_d        = NACK_STAGE_REG;
                        {oe_d, sh_d} = tx_first(reg_q);
                    end else if (stg_q == NACK_STAGE_REG) begin
                        state_d = ST_RSTART;
                    end else begin
                        state_d = ST_RX;
                        bit_d   = '0;
                    end
                end
            end
            ST_RX: begin
                if (hi_mid) begin
                    sh_d       = {sh_q[6:0], sda};
                    bit_d      = bit_q + 1'b1;
                    rd_valid_d = bit_q == 4'd7;
                    rd_data_d  = (bit_q == 4'd7) ? {sh_q[6:0], sda} : rd_data_q;
                end
                if (lo_mid && bit_q == 4'd8) begin
                    state_d = ST_MACK;
                    oe_d    = rem_q != LEN_W'(1);
                end
            end
            ST_MACK: if (lo_mid) begin
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q != LEN_W'(1)) ? ST_RX : ST_STOP;
                oe_d    = rem_q == LEN_W'(1);
                bit_d   = '0;
            end
            ST_STOP: if (hi_mid) begin
                oe_d    = 1'b0;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers; reset drops the bus immediately without a STOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            dev_q        <= '0;
            reg_q        <= '0;
            rem_q        <= '0;
            sh_q         <= '0;
            bit_q        <= '0;
            stg_q        <= NACK_STAGE_NONE;
            oe_q         <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            nack_err_q   <= 1'b0;
            nack_stage_q <= NACK_STAGE_NONE;
        end else begin
            state_q      <= state_d;
            dev_q        <= dev_d;
            reg_q        <= reg_d;
            rem_q        <= rem_d;
            sh_q         <= sh_d;
            bit_q        <= bit_d;
            stg_q        <= stg_d;
            oe_q         <= oe_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            nack_err_q   <= nack_err_d;
            nack_stage_q <= nack_stage_d;
        end
    end
endmodule

// File: tb/tb_i2c_burst_read_master.sv
// tb_i2c_burst_read_master: burst reads against a behavioural open-drain slave with memory model
module tb_i2c_burst_read_master;
    localparam int CLK_DIV   = 24;
    localparam int MAX_BYTES = 16;
    localparam int LEN_W     = 5;
    localparam int LIMIT     = 6000;
    localparam logic [6:0] SLV = 7'h50;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       dev_addr = '0;
    logic [7:0]       reg_addr = '0;
    logic [LEN_W-1:0] byte_len = '0;
    logic [7:0]       rd_data;
    logic             rd_valid, busy, done, nack_err, scl, sda_oe;
    logic [1:0]       nack_stage;
    wire              sda;

    pullup (sda);

    i2c_burst_read_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dev_addr   (dev_addr),
        .reg_addr   (reg_addr),
        .byte_len   (byte_len),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .nack_err   (nack_err),
        .nack_stage (nack_stage),
        .scl        (scl),
        .sda        (sda),
        .sda_oe     (sda_oe)
    );

    always #5 clk = ~clk;

    // behavioural slave: register-pointer memory, ACK/NACK control, bus event counters
    logic [7:0]  mem [256];
    logic        s_oe = 1'b0;
    int          s_phase = 0;
    int          s_bits = 0;
    logic [7:0]  s_sh = '0, s_ptr = '0, s_b;
    logic        s_ack = 1'b0, s_mack = 1'b0;
    bit          nack_reg = 0, nack_devr = 0;
    bit          s_clr = 0, p_clr = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1;
    int          stops = 0, macks = 0, falls = 0;
    logic [31:0] mack_mask = '0;

    assign sda = s_oe ? 1'b0 : 1'bz;

    always @(scl or sda or s_clr) begin
        if (s_clr != p_clr) begin
            s_phase = 0;
            s_bits  = 0;
            s_oe    = 1'b0;
        end else if (scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
            s_phase = 1;
            s_bits  = 0;
            s_oe    = 1'b0;
        end else if (scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
            if (busy === 1'b1) stops++;
            s_phase = 0;
            s_oe    = 1'b0;
        end else if (scl === 1'b1 && p_scl === 1'b0) begin
            if (s_phase == 1 || s_phase == 2) begin
                if (s_bits < 8) s_sh = {s_sh[6:0], sda};
                s_bits++;
            end else if (s_phase == 3) begin
                if (s_bits == 8) begin
                    macks++;
                    mack_mask = {mack_mask[30:0], sda};
                    s_mack = sda;
                end
                s_bits++;
            end
        end else if (scl === 1'b0 && p_scl === 1'b1) begin
            if (busy === 1'b1) falls++;
            if (s_phase == 1 || s_phase == 2) begin
                if (s_bits == 8) begin
                    if (s_phase == 1) s_ack = (s_sh[7:1] == SLV) && !(s_sh[0] && nack_devr);
                    else begin
                        s_ack = !nack_reg;
                        s_ptr = s_sh;
                    end
                    s_oe = s_ack;
                end else if (s_bits == 9) begin
                    s_oe   = 1'b0;
                    s_bits = 0;
                    if (!s_ack || s_phase == 2) s_phase = 0;
                    else if (s_sh[0]) begin
                        s_phase = 3;
                        s_b = mem[s_ptr];
                        s_oe = !s_b[7];
                    end else s_phase = 2;
                end
            end else if (s_phase == 3) begin
                s_b = mem[s_ptr];
                if (s_bits < 8) s_oe = !s_b[3'(7 - s_bits)];
                else if (s_bits == 8) s_oe = 1'b0;
                else begin
                    s_bits = 0;
                    if (s_mack) begin
                        s_phase = 0;
                        s_oe = 1'b0;
                    end else begin
                        s_ptr = s_ptr + 8'd1;
                        s_b = mem[s_ptr];
                        s_oe = !s_b[7];
                    end
                end
            end
        end
        p_scl = scl;
        p_sda = sda;
        p_clr = s_clr;
    end

    // stream monitor for received bytes and done pulses
    logic [7:0] got [$];
    int         dones = 0;
    always @(negedge clk) begin
        if (rd_valid === 1'b1) got.push_back(rd_data);
        if (done === 1'b1) dones++;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one complete frame, checked against the byte-count, memory and NACK rules
    task automatic run_frame(input logic [6:0] dev, input logic [7:0] ra, input logic [LEN_W-1:0] len,
                             input bit poke, input string tag);
        int n, stg, base, d0, s0, f0, m0, cyc;
        logic [31:0] lowmask;
        n = (len == 0) ? 1 : (int'(len) > MAX_BYTES) ? MAX_BYTES : int'(len);
        stg = (dev != SLV) ? 1 : nack_reg ? 2 : nack_devr ? 3 : 0;
        base = got.size(); d0 = dones; s0 = stops; m0 = macks; f0 = falls;
        @(negedge clk);
        start = 1'b1; dev_addr = dev; reg_addr = ra; byte_len = len;
        @(negedge clk);
        start = 1'b0; dev_addr = 7'($urandom); reg_addr = 8'($urandom); byte_len = LEN_W'($urandom);
        chk({tag, " busy"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            start = poke && cyc == 500;
        end
        start = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " nack_err"}, nack_err, stg != 0);
        chk({tag, " nack_stage"}, nack_stage, stg);
        @(negedge clk);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " nack_held"}, nack_err, stg != 0);
        chk({tag, " done_count"}, dones - d0, 1);
        chk({tag, " stop_count"}, stops - s0, 1);
        if (stg == 0) begin
            chk({tag, " n_bytes"}, got.size() - base, n);
            for (int i = 0; i < n && base + i < got.size(); i++)
                chk($sformatf("%s byte%0d", tag, i), got[base + i], mem[8'(ra + 8'(i))]);
            lowmask = (n == 32) ? '1 : ((32'd1 << n) - 1);
            chk({tag, " master_acks"}, macks - m0, n);
            chk({tag, " ack_pattern"}, mack_mask & lowmask, 1);
            chk({tag, " scl_periods"}, falls - f0 + 1, 30 + 9 * n);
        end else begin
            chk({tag, " no_data"}, got.size() - base, 0);
        end
    endtask

    initial begin
        int base, cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'(i + 1);
        repeat (3) @(negedge clk);
        chk("rst scl", scl, 1);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst sda", sda, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst nack", {nack_err, nack_stage}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(SLV, 8'h10, 1, 0, "t1");
        chk("t1 data", got[got.size() - 1], 8'hA5);
        run_frame(SLV, 8'h20, 4, 0, "t2");
        run_frame(7'h3C, 8'h00, 2, 0, "t3");
        nack_reg = 1;
        run_frame(SLV, 8'h30, 2, 0, "t4reg");
        nack_reg = 0;
        nack_devr = 1;
        run_frame(SLV, 8'h30, 2, 0, "t4devr");
        nack_devr = 0;
        base = got.size();
        @(negedge clk);
        start = 1'b1; dev_addr = SLV; reg_addr = 8'h40; byte_len = 4;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (got.size() == base && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5 first_byte", got.size() - base, 1);
        repeat (3 * CLK_DIV) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5 scl", scl, 1);
        chk("t5 sda_oe", sda_oe, 0);
        chk("t5 busy", busy, 0);
        chk("t5 done", done, 0);
        s_clr = !s_clr;
        #1 chk("t5 sda", sda, 1);
        @(negedge clk);
        rst = 1'b1;
        chk("t5 bytes", got.size() - base, 1);
        run_frame(SLV, 8'($urandom), 1, 0, "t5b");
        run_frame(SLV, 8'h50, 3, 1, "t6poke");
        run_frame(SLV, 8'h60, 0, 0, "t6len0");
        run_frame(SLV, 8'hF8, 31, 0, "t6len31");
        for (int k = 0; k < 5; k++)
            run_frame(SLV, 8'($urandom), LEN_W'($urandom_range(0, 31)), 0, $sformatf("rnd%0d", k));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
